// File: rtl/az_sequencer.sv
// Autozero phase sequencer: startup hold, periodic and on-demand phi_az pulses deferred around trigger windows.
// Optional pulse-deferral counter (defer_cnt/defer_clr) is built when AZ_DEFER_CNT_EN is defined.
//
// state   | meaning
// STARTUP | phi_az held high until the first global pulse
// IDLE    | phi_az low, period counter running
// WAIT    | pulse due, deferred until trig_busy drops
// PULSE   | phi_az high for the latched width
// GUARD   | phi_az low settling time, ack issued on exit
module az_sequencer #(
  parameter int PERIOD_W     = 16,
  parameter int WIDTH_W      = 8,
  parameter int GUARD_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset_b,
  input  logic                pulse,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] az_period,
  input  logic [WIDTH_W-1:0]  az_width,
  input  logic                trig_busy,
  input  logic                az_req,
  output logic                az_ack,
  output logic                phi_az,
  output logic                az_active
`ifdef AZ_DEFER_CNT_EN
  ,
  input  logic                defer_clr,
  output logic [7:0]          defer_cnt
`endif
);

  localparam int GUARD_W = $clog2(GUARD_CYCLES + 1);

  typedef enum logic [2:0] {ST_STARTUP, ST_IDLE, ST_WAIT, ST_PULSE, ST_GUARD} state_t;

  state_t              state, state_nx;
  logic [PERIOD_W-1:0] cnt, cnt_nx;
  logic [WIDTH_W-1:0]  wcnt, wcnt_nx;
  logic [GUARD_W-1:0]  gcnt, gcnt_nx;
  logic                served, served_nx;
  logic                ack_nx;
  logic                req_pending;
  logic                az_req_d;
  logic                counting;
  logic                expiry;
  logic                go_pulse;

  assign counting = enable && (az_period != '0);
  assign expiry   = counting && (cnt == az_period - PERIOD_W'(1));

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    wcnt_nx   = wcnt;
    gcnt_nx   = gcnt;
    served_nx = served;
    ack_nx    = 1'b0;
    go_pulse  = 1'b0;
    case (state)
      ST_STARTUP: begin
        if (pulse) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end
      end
      ST_IDLE: begin
        cnt_nx = counting ? cnt + PERIOD_W'(1) : '0;
        if (expiry || req_pending) begin
          if (trig_busy) state_nx = ST_WAIT;
          else           go_pulse = 1'b1;
        end
      end
      ST_WAIT: begin
        if (!trig_busy) go_pulse = 1'b1;
      end
      ST_PULSE: begin
        if (wcnt <= WIDTH_W'(1)) begin
          state_nx = ST_GUARD;
          gcnt_nx  = GUARD_W'(GUARD_CYCLES);
        end else begin
          wcnt_nx = wcnt - WIDTH_W'(1);
        end
      end
      ST_GUARD: begin
        if (gcnt <= GUARD_W'(1)) begin
          state_nx  = ST_IDLE;
          cnt_nx    = '0;
          ack_nx    = served;
          served_nx = 1'b0;
        end else begin
          gcnt_nx = gcnt - GUARD_W'(1);
        end
      end
      default: state_nx = ST_STARTUP;
    endcase
    // The request that gets acked is the one pending when the pulse starts.
    if (go_pulse) begin
      state_nx  = ST_PULSE;
      wcnt_nx   = (az_width == '0) ? WIDTH_W'(1) : az_width;
      served_nx = req_pending;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state     <= ST_STARTUP;
      cnt       <= '0;
      wcnt      <= '0;
      gcnt      <= '0;
      served    <= 1'b0;
      phi_az    <= 1'b1;
      az_active <= 1'b1;
      az_ack    <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      wcnt      <= wcnt_nx;
      gcnt      <= gcnt_nx;
      served    <= served_nx;
      phi_az    <= (state_nx == ST_STARTUP) || (state_nx == ST_PULSE);
      az_active <= (state_nx != ST_IDLE);
      az_ack    <= ack_nx;
    end
  end

  // A new edge in the ack cycle wins over the clear.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      req_pending <= 1'b0;
      az_req_d    <= 1'b0;
    end else begin
      az_req_d <= az_req;
      if ((state != ST_STARTUP) && az_req && !az_req_d) req_pending <= 1'b1;
      else if (ack_nx)                                  req_pending <= 1'b0;
    end
  end

`ifdef AZ_DEFER_CNT_EN
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      defer_cnt <= '0;
    end else if (defer_clr) begin
      defer_cnt <= '0;
    end else if ((state_nx == ST_WAIT) && (state != ST_WAIT) && (defer_cnt != 8'hFF)) begin
      defer_cnt <= defer_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_az_sequencer.sv
// Bench for az_sequencer: directed timing table, hand-written corner sequences and a randomized run
// checked every cycle against an event-level model of the autozero rules.
module tb_az_sequencer;

  localparam int GUARD = 4;

  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic        pulse = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] az_period = '0;
  logic [7:0]  az_width = '0;
  logic        trig_busy = 1'b0;
  logic        az_req = 1'b0;
  logic        az_ack, phi_az, az_active;
`ifdef AZ_DEFER_CNT_EN
  logic        defer_clr = 1'b0;
  logic [7:0]  defer_cnt;
`endif

  always #5 clk = ~clk;

  az_sequencer #(.PERIOD_W(16), .WIDTH_W(8), .GUARD_CYCLES(GUARD)) dut (
    .clk       (clk),
    .reset_b   (reset_b),
    .pulse     (pulse),
    .enable    (enable),
    .az_period (az_period),
    .az_width  (az_width),
    .trig_busy (trig_busy),
    .az_req    (az_req),
    .az_ack    (az_ack),
    .phi_az    (phi_az),
    .az_active (az_active)
`ifdef AZ_DEFER_CNT_EN
    ,
    .defer_clr (defer_clr),
    .defer_cnt (defer_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase plus elapsed-cycle bookkeeping.
  localparam int P_START = 0, P_IDLE = 1, P_WAIT = 2, P_PULSE = 3, P_GUARD = 4;
  int m_phase, m_age, m_len, m_done, m_pending, m_owed, m_req_prev, m_ack, m_defer;

  task automatic model_reset();
    m_phase = P_START; m_age = 0; m_len = 0; m_done = 0;
    m_pending = 0; m_owed = 0; m_req_prev = 0; m_ack = 0; m_defer = 0;
  endtask

  task automatic model_edge();
    int new_edge, counting, due, go, ack_now, wait_entry;
    new_edge   = (m_phase != P_START && az_req && !m_req_prev) ? 1 : 0;
    counting   = (enable && az_period != 0) ? 1 : 0;
    go = 0; ack_now = 0; wait_entry = 0;
    case (m_phase)
      P_START: if (pulse) begin m_phase = P_IDLE; m_age = 0; end
      P_IDLE: begin
        due = ((counting != 0 && m_age == int'(az_period) - 1) || m_pending != 0) ? 1 : 0;
        m_age = (counting != 0) ? m_age + 1 : 0;
        if (due != 0) begin
          if (trig_busy) begin m_phase = P_WAIT; wait_entry = 1; end
          else go = 1;
        end
      end
      P_WAIT: if (!trig_busy) go = 1;
      P_PULSE: begin
        m_done++;
        if (m_done == m_len) begin m_phase = P_GUARD; m_done = 0; end
      end
      default: begin
        m_done++;
        if (m_done == GUARD) begin
          m_phase = P_IDLE; m_age = 0; ack_now = m_owed; m_owed = 0;
        end
      end
    endcase
    if (go != 0) begin
      m_phase = P_PULSE; m_done = 0;
      m_len   = (az_width == 0) ? 1 : int'(az_width);
      m_owed  = m_pending;
    end
    m_ack = ack_now;
    if (ack_now != 0) m_pending = 0;
    if (new_edge != 0) m_pending = 1;
    m_req_prev = az_req ? 1 : 0;
`ifdef AZ_DEFER_CNT_EN
    if (defer_clr) m_defer = 0;
    else if (wait_entry != 0 && m_defer < 255) m_defer++;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset_b) model_reset();
    else model_edge();
    #1;
    check("phi_az", phi_az, (m_phase == P_START || m_phase == P_PULSE) ? 1 : 0);
    check("az_active", az_active, (m_phase != P_IDLE) ? 1 : 0);
    check("az_ack", az_ack, m_ack);
`ifdef AZ_DEFER_CNT_EN
    check("defer_cnt", defer_cnt, m_defer);
`endif
  endtask

  task automatic enter_idle();
    reset_b = 1'b0; az_req = 1'b0; trig_busy = 1'b0; pulse = 1'b0;
    tick(); tick();
    reset_b = 1'b1;
    tick();
    pulse = 1'b1;
    tick();
    pulse = 1'b0;
  endtask

  task automatic count_until(input logic level, input int bound, output int n);
    n = 0;
    while (phi_az !== level && n < bound) begin tick(); n++; end
  endtask

  typedef struct {
    int period;
    int width;
    int exp_rise;
    int exp_high;
    int exp_interval;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int n, w, l, cnt_hi, cnt_ack;
    model_reset();
    vecs[0] = '{100, 5, 100, 5, 109};
    vecs[1] = '{10,  0, 10,  1, 15};
    vecs[2] = '{3,   2, 3,   2, 9};
    vecs[3] = '{1,   3, 1,   3, 8};

    // Startup hold and release
    tick(); tick();
    check("reset_phi", phi_az, 1);
    check("reset_active", az_active, 1);
    check("reset_ack", az_ack, 0);
    reset_b = 1'b1;
    enable = 1'b1; az_period = 16'd7; az_req = 1'b1; trig_busy = 1'b1;
    cnt_hi = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (phi_az === 1'b1 && az_active === 1'b1) cnt_hi++;
    end
    check("startup_hold_cycles", cnt_hi, 50);
    az_req = 1'b0; trig_busy = 1'b0;
    pulse = 1'b1;
    tick();
    pulse = 1'b0;
    check("startup_release_phi", phi_az, 0);
    check("startup_release_active", az_active, 0);

    // Periodic timing table
    foreach (vecs[k]) begin
      enable = 1'b1;
      az_period = 16'(vecs[k].period);
      az_width = 8'(vecs[k].width);
      enter_idle();
      count_until(1'b1, 2000, n);
      check($sformatf("rise_v%0d", k), n, vecs[k].exp_rise);
      count_until(1'b0, 2000, w);
      check($sformatf("high_v%0d", k), w, vecs[k].exp_high);
      count_until(1'b1, 2000, l);
      check($sformatf("interval_v%0d", k), w + l, vecs[k].exp_interval);
    end

    // Deferral around a trigger window
    enable = 1'b1; az_period = 16'd100; az_width = 8'd5;
    enter_idle();
    for (int i = 0; i < 97; i++) tick();
    trig_busy = 1'b1;
    cnt_hi = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (phi_az !== 1'b0) cnt_hi++;
    end
    check("busy_no_phi", cnt_hi, 0);
    trig_busy = 1'b0;
    count_until(1'b1, 500, n);
    check("busy_release_latency", n, 1);
`ifdef AZ_DEFER_CNT_EN
    check("defer_cnt_one", defer_cnt, 1);
`endif

    // On-demand request with periodic disabled
    enable = 1'b0; az_width = 8'd3;
    enter_idle();
    for (int i = 0; i < 5; i++) tick();
    az_req = 1'b1;
    count_until(1'b1, 100, n);
    check("req_latency", n, 2);
    count_until(1'b0, 100, w);
    check("req_width", w, 3);
    l = 0;
    while (az_ack !== 1'b1 && l < 50) begin tick(); l++; end
    check("req_ack_delay", l, GUARD);
    tick();
    check("req_ack_one_cycle", az_ack, 0);
    cnt_hi = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (phi_az === 1'b1) cnt_hi++;
    end
    check("req_held_no_repeat", cnt_hi, 0);
    az_req = 1'b0;

    // Periodic off via az_period=0
    enable = 1'b1; az_period = 16'd0; az_width = 8'd2;
    enter_idle();
    cnt_hi = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (phi_az === 1'b1) cnt_hi++;
    end
    check("period0_no_pulse", cnt_hi, 0);

    // Reset in the middle of a requested pulse
    enable = 1'b0; az_width = 8'd6;
    enter_idle();
    az_req = 1'b1;
    count_until(1'b1, 100, n);
    tick(); tick();
    reset_b = 1'b0;
    #1;
    check("midreset_phi", phi_az, 1);
    check("midreset_active", az_active, 1);
    check("midreset_ack", az_ack, 0);
    tick();
    reset_b = 1'b1;
    cnt_hi = 0; cnt_ack = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (phi_az === 1'b1) cnt_hi++;
      if (az_ack === 1'b1) cnt_ack++;
    end
    check("midreset_waits_pulse", cnt_hi, 30);
    check("midreset_no_ack", cnt_ack, 0);
    az_req = 1'b0;

    // Randomized run against the model
    for (int c = 0; c < 6000; c++) begin
      if (c % 400 == 0) begin
        az_period = 16'($urandom_range(0, 25));
        az_width  = 8'($urandom_range(0, 6));
        enable    = ($urandom_range(0, 9) != 0);
      end
      if ($urandom_range(0, 7) == 0) trig_busy = ~trig_busy;
      pulse = ($urandom_range(0, 49) == 0);
      if (az_req && az_ack === 1'b1) az_req = 1'b0;
      else if (!az_req && $urandom_range(0, 30) == 0) az_req = 1'b1;
`ifdef AZ_DEFER_CNT_EN
      defer_clr = ($urandom_range(0, 99) == 0);
`endif
      if ($urandom_range(0, 1499) == 0) begin
        reset_b = 1'b0;
        az_req = 1'b0;
      end else begin
        reset_b = 1'b1;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
